tdm_tx_arbiter: RTL and testbench

//  Round-robin scheduler that shares the single TDM byte serializer between
//  NUM_REQ byte sources. Accepts one byte per frame from the winning requester
//  via valid/ready handshake. Issues a one-cycle tx_valid/tx_data to the

---
 rtl/tdm_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_tdm_tx_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_tx_arbiter.sv
// tdm_tx_arbiter
// Round-robin scheduler feeding one byte per frame into a shared TDM
// serializer. A granted byte is presented for one cycle on tx_valid/tx_data,
// then no new grant is issued until all DATA_W bits (plus GAP_CYCLES idle
// cycles) have been shifted out.
module tdm_tx_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_W     = 8,
   parameter int GAP_CYCLES = 0,
   localparam int ID_W      = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [DATA_W-1:0]         tx_data,
   output logic                      tx_valid,
   output logic [ID_W-1:0]           grant_id,
   output logic                      busy,
   output logic                      frame_done
);

   localparam int FRAME   = DATA_W + GAP_CYCLES;
   localparam int CNT_MAX = (FRAME >= 2) ? FRAME - 2 : 0;
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
   localparam int unsigned NR = NUM_REQ;

   if (FRAME < 2) begin : g_bad_frame
      $error("tdm_tx_arbiter: DATA_W+GAP_CYCLES must be at least 2");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [DATA_W-1:0]  tx_data_q, tx_data_d;
   logic [ID_W-1:0]    grant_id_q, grant_id_d;
   logic [ID_W-1:0]    last_grant_q, last_grant_d;

   logic [ID_W-1:0]    winner;
   logic [ID_W-1:0]    cand;
   logic               found;
   logic               accept_win;

   // Rotating priority search starting just after the last granted requester
   always_comb begin
      winner = '0;
      cand   = '0;
      found  = 1'b0;
      for (int unsigned k = 1; k <= NR; k++) begin
         cand = ID_W'((32'(last_grant_q) + k) % NR);
         if (!found && req_valid[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   // Accept window, handshake strobe and next-state logic
   always_comb begin
      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      tx_data_d    = tx_data_q;
      grant_id_d   = grant_id_q;
      last_grant_d = last_grant_q;
      req_ready    = '0;

      accept_win = en && (|req_valid) &&
                   ((state_q == IDLE) || ((state_q == HOLD) && (hold_cnt_q == '0)));

      if (accept_win) begin
         req_ready[winner] = 1'b1;
         tx_data_d         = req_data[int'(winner)*DATA_W +: DATA_W];
         grant_id_d        = winner;
         last_grant_d      = winner;
      end

      unique case (state_q)
         IDLE: begin
            if (accept_win) state_d = SEND;
         end
         SEND: begin
            state_d    = HOLD;
            hold_cnt_d = CNT_W'(CNT_MAX);
         end
         HOLD: begin
            if (hold_cnt_q == '0) begin
               state_d = accept_win ? SEND : IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         hold_cnt_q   <= '0;
         tx_data_q    <= '0;
         grant_id_q   <= '0;
         last_grant_q <= ID_W'(NUM_REQ - 1);
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         tx_data_q    <= tx_data_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign tx_data    = tx_data_q;
   assign grant_id   = grant_id_q;
   assign tx_valid   = (state_q == SEND);
   assign busy       = (state_q != IDLE);
   assign frame_done = (state_q == HOLD) && (hold_cnt_q == '0);

endmodule

// File: tb/tb_tdm_tx_arbiter.sv
// Testbench for tdm_tx_arbiter: two instances (no gap, gap of 2) share the
// same stimulus; each is compared every cycle with a frame-timing model based
// on accept-cycle arithmetic, plus directed literal expectations.
module tb_tdm_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [3:0]  rv = '0;
   logic [31:0] rd = '0;

   logic [3:0]  rdy  [2];
   logic [7:0]  txd  [2];
   logic        txv  [2];
   logic [1:0]  gid  [2];
   logic        bsy  [2];
   logic        fd   [2];

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   // model state per instance
   int          t_acc  [2];
   int          last_g [2];
   logic [7:0]  m_data [2];
   int          m_id   [2];

   // tx_valid events seen: grant id, cycle, data
   int ev_id [2][$];
   int ev_t  [2][$];
   int ev_d  [2][$];

   always #5 clk = ~clk;

   tdm_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .en(en), .req_valid(rv), .req_data(rd),
      .req_ready(rdy[0]), .tx_data(txd[0]), .tx_valid(txv[0]),
      .grant_id(gid[0]), .busy(bsy[0]), .frame_done(fd[0]));

   tdm_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .req_valid(rv), .req_data(rd),
      .req_ready(rdy[1]), .tx_data(txd[1]), .tx_valid(txv[1]),
      .grant_id(gid[1]), .busy(bsy[1]), .frame_done(fd[1]));

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input int last, input logic [3:0] v);
      logic [3:0] vv;
      vv = v;
      for (int k = 1; k <= 4; k++) begin
         if (vv[(last + k) % 4]) return (last + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic [7:0] byte_of(input logic [31:0] d, input int i);
      return d[i*8 +: 8];
   endfunction

   // Per-cycle compare against the frame-timing model
   always @(negedge clk) begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            t_acc[i]  = cyc - 1000;
            last_g[i] = 3;
            m_data[i] = '0;
            m_id[i]   = 0;
            check($sformatf("rst_ready%0d", i), int'(rdy[i]), 0);
            check($sformatf("rst_txv%0d", i), int'(txv[i]), 0);
            check($sformatf("rst_busy%0d", i), int'(bsy[i]), 0);
            check($sformatf("rst_fd%0d", i), int'(fd[i]), 0);
            check($sformatf("rst_txd%0d", i), int'(txd[i]), 0);
            check($sformatf("rst_gid%0d", i), int'(gid[i]), 0);
         end else begin
            int p, w, exp_rdy;
            bit in_frame, last_cyc, can;
            p        = (i == 0) ? 8 : 10;
            in_frame = (cyc >= t_acc[i] + 1) && (cyc <= t_acc[i] + p);
            last_cyc = (cyc == t_acc[i] + p);
            can      = en && (rv != 0) && (!in_frame || last_cyc);
            w        = pick(last_g[i], rv);
            exp_rdy  = can ? (1 << w) : 0;
            check($sformatf("ready%0d", i), int'(rdy[i]), exp_rdy);
            check($sformatf("txv%0d", i), int'(txv[i]), int'(cyc == t_acc[i] + 1));
            check($sformatf("busy%0d", i), int'(bsy[i]), int'(in_frame));
            check($sformatf("fd%0d", i), int'(fd[i]), int'(last_cyc));
            check($sformatf("txd%0d", i), int'(txd[i]), int'(m_data[i]));
            check($sformatf("gid%0d", i), int'(gid[i]), m_id[i]);
            if (txv[i]) begin
               ev_id[i].push_back(int'(gid[i]));
               ev_t[i].push_back(cyc);
               ev_d[i].push_back(int'(txd[i]));
            end
            if (can) begin
               t_acc[i]  = cyc;
               last_g[i] = w;
               m_data[i] = byte_of(rd, w);
               m_id[i]   = w;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clr();
      for (int i = 0; i < 2; i++) begin
         ev_id[i].delete();
         ev_t[i].delete();
         ev_d[i].delete();
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rv    = '0;
      tick(3);
      rst_n = 1'b1;
   endtask

   initial begin
      int nb, fd_at, lows;
      bit seen;
      en = 1'b1;
      do_reset();

      // single requester 2, byte A5
      rv = 4'b0100;
      rd = 32'h00A5_0000;
      @(negedge clk);
      check("t1_ready", int'(rdy[0]), 4'b0100);
      @(posedge clk); #1;
      rv = '0;
      @(negedge clk);
      check("t1_txv", int'(txv[0]), 1);
      check("t1_txd", int'(txd[0]), 8'hA5);
      check("t1_gid", int'(gid[0]), 2);
      nb = 0; fd_at = 0;
      for (int k = 0; k < 20; k++) begin
         if (bsy[0]) nb++;
         if (fd[0] && fd_at == 0) fd_at = k + 1;
         @(negedge clk);
      end
      check("t1_busy_len", nb, 8);
      check("t1_fd_at", fd_at, 8);
      @(posedge clk); #1;

      // all four requesting, back-to-back frames
      do_reset();
      rd = 32'h4433_2211;
      rv = 4'b1111;
      clr();
      tick(45);
      if (ev_id[0].size() < 5 || ev_id[1].size() < 5) begin
         check("t2_nevents", ev_id[0].size(), 5);
      end else begin
         for (int j = 0; j < 5; j++) begin
            check("t2_gid0", ev_id[0][j], j % 4);
            check("t2_dat0", ev_d[0][j], (j % 4 + 1) * 8'h11);
            check("t2_gid1", ev_id[1][j], j % 4);
            if (j > 0) begin
               check("t2_space0", ev_t[0][j] - ev_t[0][j-1], 8);
               check("t2_space1", ev_t[1][j] - ev_t[1][j-1], 10);
            end
         end
      end

      // gap instance, two requesters; busy must not drop across the gap
      do_reset();
      rv = 4'b0011;
      clr();
      seen = 0; lows = 0;
      for (int k = 0; k < 35; k++) begin
         @(negedge clk);
         if (txv[1]) seen = 1;
         else if (seen && !bsy[1]) lows++;
         @(posedge clk); #1;
      end
      check("t3_busy_gap", lows, 0);
      if (ev_id[1].size() < 3) begin
         check("t3_nevents", ev_id[1].size(), 3);
      end else begin
         check("t3_g0", ev_id[1][0], 0);
         check("t3_g1", ev_id[1][1], 1);
         check("t3_g2", ev_id[1][2], 0);
         check("t3_space", ev_t[1][2] - ev_t[1][1], 10);
      end

      // skip non-requesters; en low blocks new grants
      do_reset();
      clr();
      rv = 4'b0010;
      tick(1);
      rv = 4'b1010;
      tick(24);
      if (ev_id[0].size() < 3) begin
         check("t4_nevents", ev_id[0].size(), 3);
      end else begin
         check("t4_g0", ev_id[0][0], 1);
         check("t4_g1", ev_id[0][1], 3);
         check("t4_g2", ev_id[0][2], 1);
      end
      en = 1'b0;
      rv = 4'b0001;
      tick(20);
      @(negedge clk);
      check("t4_no_ready", int'(rdy[0]), 0);
      check("t4_idle", int'(bsy[0]), 0);
      @(posedge clk); #1;

      // en dropped mid-frame
      do_reset();
      en = 1'b1;
      rv = 4'b1111;
      tick(4);
      en = 1'b0;
      clr();
      tick(30);
      check("t5_no_txv", ev_id[0].size(), 0);
      check("t5_idle", int'(bsy[0]), 0);
      en = 1'b1;
      tick(10);
      check("t5_resume", int'(ev_id[0].size() > 0), 1);

      // asynchronous reset mid-frame
      tick(3);
      #2;
      rst_n = 1'b0;
      rv    = '0;
      #1;
      for (int i = 0; i < 2; i++) begin
         check("t6_txv", int'(txv[i]), 0);
         check("t6_busy", int'(bsy[i]), 0);
         check("t6_txd", int'(txd[i]), 0);
         check("t6_gid", int'(gid[i]), 0);
         check("t6_fd", int'(fd[i]), 0);
      end
      tick(3);
      rst_n = 1'b1;
      rv = 4'b1111;
      clr();
      tick(5);
      check("t6_first0", (ev_id[0].size() > 0) ? ev_id[0][0] : -1, 0);
      check("t6_first1", (ev_id[1].size() > 0) ? ev_id[1][0] : -1, 0);

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            rv    = '0;
            tick(2);
            rst_n = 1'b1;
         end
         en = ($urandom_range(0, 7) != 0);
         rv = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         rd = $urandom;
         tick(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
